pc_unit: RTL and testbench
==========================

# pc_unit

Program counter stage of the 16-bit CPU. Holds the current fetch address and computes the next one from increment, branch, jump, call and return requests. Its `pc` output drives instruction memory. Its `pc_plus1` output feeds the link/next-address 2:1 muxes in the datapath. An optional return-address stack (RAS) handles call/return without using the register file.

## Interface
Parameters:
- `WIDTH`, 16, address width in bits.
- `RESET_VECTOR`, 16'h0000, value loaded into `pc` on reset.
- `RAS_DEPTH`, 4, number of RAS entries (power of two, 2–16). Used only when the RAS is compiled in.

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `stall`  input  1  hold all state this cycle.
- `branch_taken`  input  1  conditional branch resolved taken.
- `branch_target`  input  WIDTH  branch destination.
- `jump`  input  1  unconditional jump.
- `call`  input  1  jump that also pushes the return address.
- `jump_target`  input  WIDTH  destination for `jump` and `call`.
- `ret`  input  1  return to the address on top of the RAS.
- `pc`  output  WIDTH  current fetch address; registered.
- `pc_plus1`  output  WIDTH  `pc + 1`, combinational, modulo 2^WIDTH.
- `fetch_valid`  output  1  `pc` holds a fetchable address; registered.
- `ras_count`  output  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- `ras_ovf`  output  1  sticky flag: a push was made while the RAS was full.
- `ras_unf`  output  1  sticky flag: a pop was made while the RAS was empty.

## Operation
Next-PC priority, highest first:
- `reset`: `pc` = RESET_VECTOR; `fetch_valid` = 0; RAS emptied (`ras_count` = 0); `ras_ovf` = 0; `ras_unf` = 0.
- `stall`: all registers hold, including the RAS and the sticky flags. Every redirect input is ignored.
- `ret`:
  - RAS non-empty: pop the top entry; `pc` takes the popped value.
  - RAS empty: `pc` = `pc_plus1`; set `ras_unf`.
- `call`: push `pc_plus1`; `pc` = `jump_target`.
  - RAS full: overwrite the oldest entry (the RAS is circular); `ras_count` stays at RAS_DEPTH; set `ras_ovf`.
- `jump`: `pc` = `jump_target`.
- `branch_taken`: `pc` = `branch_target`.
- Otherwise: `pc` = `pc_plus1`.

Simultaneous requests:
- `ret` together with `call`: `ret` wins; no push is made.
- `call` together with `jump`: treated as a `call`.

Other rules:
- `fetch_valid` becomes 1 on the first non-reset clock edge and stays 1 until the next reset. `stall` does not clear it.
- Address arithmetic is unsigned modulo 2^WIDTH. 16'hFFFF increments to 16'h0000 with no flag.
- RAS storage: a WIDTH × RAS_DEPTH register array with a top pointer. Entry contents are not reset; only the pointer and count are cleared.

## Timing
- Redirect latency is one cycle: a request sampled at edge N appears on `pc` after edge N.
- `pc_plus1` follows `pc` combinationally within the same cycle.
- After reset deasserts: the first edge keeps `pc` at RESET_VECTOR and raises `fetch_valid`; the second edge advances `pc` normally. This gives exactly one cycle of fetch at RESET_VECTOR.
- Reset during a stall, or mid-sequence, takes effect on that edge with no residual state.
- RAS push and pop complete in the same edge as the `pc` update. A `ret` on the cycle immediately after a `call` returns that call's address.

## Configuration
- Macro: `PC_UNIT_RAS_EN`.
- Defined: RAS present; behaviour exactly as above.
- Undefined:
  - No RAS storage is instantiated.
  - `call` behaves as `jump`.
  - `ret` is ignored; the priority chain continues with `call`/`jump`/`branch_taken`, else `pc` = `pc_plus1`.
  - `ras_count`, `ras_ovf` and `ras_unf` are tied to 0.

## Test plan
- Reset, then release and run 3 free cycles -> `pc` = 0000, 0000, 0001, 0002; `fetch_valid` 0 during reset, 1 after the first edge.
- Load `pc` = FFFE, then 2 free cycles -> `pc` = FFFF, then 0000; `pc_plus1` = 0000, then 0001.
- Assert `branch_taken`=1, `branch_target`=0040 and `stall`=1 for 2 cycles, then `stall`=0 -> `pc` holds 2 cycles, then becomes 0040.
- At `pc`=0010: `call` to 0100; at 0100: `call` to 0200; then `ret`, `ret` -> `pc` = 0100, 0200, 0101, 0011; `ras_count` = 1, 2, 1, 0.
- Make 5 calls with RAS_DEPTH=4, then 5 rets -> `ras_ovf`=1 after the 5th call; 4 correct returns (newest first); 5th ret gives `pc_plus1` and `ras_unf`=1.
- `ret` and `call` asserted together with an empty RAS -> `pc` = `pc_plus1`, `ras_unf`=1, `ras_count` stays 0. Repeat with the macro undefined -> `pc` = `jump_target`, flags stay 0.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Program counter stage. It computes the next fetch address from
//            increment, branch, jump, call and return requests. When
//            PC_UNIT_RAS_EN is defined, call and return use a circular
//            return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [WIDTH-1:0]           branch_target,
    input  logic                       jump,
    input  logic                       call,
    input  logic [WIDTH-1:0]           jump_target,
    input  logic                       ret,
    output logic [WIDTH-1:0]           pc,
    output logic [WIDTH-1:0]           pc_plus1,
    output logic                       fetch_valid,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_ovf,
    output logic                       ras_unf
);

    localparam int c_CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fv_q;

    assign pc          = pc_q;
    assign pc_plus1    = pc_q + WIDTH'(1);
    assign fetch_valid = fv_q;

`ifdef PC_UNIT_RAS_EN
    localparam int c_PTR_W = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0]   ras_mem_q [RAS_DEPTH];
    logic [c_PTR_W-1:0] top_q, top_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               w_push;
    logic [c_PTR_W-1:0] w_top_m1;

    // top_q points at the next free slot; when full it points at the oldest entry
    assign w_top_m1 = top_q - c_PTR_W'(1);

    always_comb begin
        pc_d   = pc_q;
        top_d  = top_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        w_push = 1'b0;
        // The first edge after reset only raises fetch_valid, so RESET_VECTOR is fetched once
        if (!stall && fv_q) begin
            if (ret) begin
                if (cnt_q != '0) begin
                    pc_d  = ras_mem_q[w_top_m1];
                    top_d = w_top_m1;
                    cnt_d = cnt_q - c_CNT_W'(1);
                end else begin
                    pc_d  = pc_plus1;
                    unf_d = 1'b1;
                end
            end else if (call) begin
                w_push = 1'b1;
                pc_d   = jump_target;
                top_d  = top_q + c_PTR_W'(1);
                if (cnt_q == c_CNT_W'(RAS_DEPTH)) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end else if (jump) begin
                pc_d = jump_target;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry contents carry no reset; only the pointer and count are cleared
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            ras_mem_q[top_q] <= pc_plus1;
        end
    end

    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
`else
    logic unused_ret;

    always_comb begin
        pc_d = pc_q;
        if (!stall && fv_q) begin
            if (call || jump) begin
                pc_d = jump_target;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus1;
            end
        end
    end

    assign unused_ret = ret;
    assign ras_count  = '0;
    assign ras_ovf    = 1'b0;
    assign ras_unf    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
            fv_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            fv_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed self-checking bench for pc_unit. Expected values follow
//            whether PC_UNIT_RAS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, call, ret;
    logic [15:0] branch_target, jump_target;
    logic [15:0] pc, pc_plus1;
    logic        fetch_valid, ras_ovf, ras_unf;
    logic [2:0]  ras_count;

    int nvec = 0;
    int nerr = 0;

    pc_unit #(.WIDTH(16), .RESET_VECTOR(16'h0000), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .call(call), .jump_target(jump_target), .ret(ret),
        .pc(pc), .pc_plus1(pc_plus1), .fetch_valid(fetch_valid),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] call_tgt [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500};
`ifdef PC_UNIT_RAS_EN
    logic [2:0]  call_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [15:0] ret_pc   [5] = '{16'h0401, 16'h0301, 16'h0201, 16'h0101, 16'h0102};
    logic [2:0]  ret_cnt  [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
`else
    logic [2:0]  call_cnt [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [15:0] ret_pc   [5] = '{16'h0501, 16'h0502, 16'h0503, 16'h0504, 16'h0505};
    logic [2:0]  ret_cnt  [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        call = 1'b0; ret = 1'b0; branch_target = '0; jump_target = '0;

        // Reset state
        step();
        check("rst_pc", pc, 16'h0000);
        check("rst_fv", fetch_valid, 1'b0);
        check("rst_cnt", ras_count, 3'd0);
        check("rst_flags", {ras_ovf, ras_unf}, 2'b00);
        check("rst_plus1", pc_plus1, 16'h0001);

        // Release: one fetch at the reset vector, then increment
        reset = 1'b0;
        step(); check("rel0_pc", pc, 16'h0000); check("rel0_fv", fetch_valid, 1'b1);
        step(); check("rel1_pc", pc, 16'h0001);
        step(); check("rel2_pc", pc, 16'h0002); check("rel2_plus1", pc_plus1, 16'h0003);

        // Wrap-around
        jump = 1'b1; jump_target = 16'hFFFE;
        step(); check("jmp_pc", pc, 16'hFFFE);
        jump = 1'b0;
        step(); check("wrap0_pc", pc, 16'hFFFF); check("wrap0_plus1", pc_plus1, 16'h0000);
        step(); check("wrap1_pc", pc, 16'h0000); check("wrap1_plus1", pc_plus1, 16'h0001);

        // Stall holds off a pending branch
        branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1;
        step(); check("stall0_pc", pc, 16'h0000);
        step(); check("stall1_pc", pc, 16'h0000); check("stall_fv", fetch_valid, 1'b1);
        stall = 1'b0;
        step(); check("br_pc", pc, 16'h0040);
        branch_taken = 1'b0;

        // Nested call / return
        jump = 1'b1; jump_target = 16'h0010;
        step(); check("jmp10_pc", pc, 16'h0010);
        jump = 1'b0; call = 1'b1; jump_target = 16'h0100;
        step(); check("call1_pc", pc, 16'h0100);
`ifdef PC_UNIT_RAS_EN
        check("call1_cnt", ras_count, 3'd1);
`endif
        jump_target = 16'h0200;
        step(); check("call2_pc", pc, 16'h0200);
        call = 1'b0; ret = 1'b1;
`ifdef PC_UNIT_RAS_EN
        check("call2_cnt", ras_count, 3'd2);
        step(); check("ret1_pc", pc, 16'h0101); check("ret1_cnt", ras_count, 3'd1);
        step(); check("ret2_pc", pc, 16'h0011); check("ret2_cnt", ras_count, 3'd0);
`else
        step(); check("ret1_pc", pc, 16'h0201); check("ret1_cnt", ras_count, 3'd0);
        step(); check("ret2_pc", pc, 16'h0202); check("ret2_flags", {ras_ovf, ras_unf}, 2'b00);
`endif
        ret = 1'b0;

        // Reset mid-sequence while stalled
        reset = 1'b1; stall = 1'b1;
        step(); check("rst2_pc", pc, 16'h0000); check("rst2_fv", fetch_valid, 1'b0);
        reset = 1'b0; stall = 1'b0;
        step(); check("rel3_pc", pc, 16'h0000);
        jump = 1'b1; jump_target = 16'h0020;
        step(); check("jmp20_pc", pc, 16'h0020);
        jump = 1'b0;

        // RAS overflow then drain to underflow
        call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jump_target = call_tgt[i];
            step();
            check($sformatf("ovf_call%0d_pc", i), pc, call_tgt[i]);
            check($sformatf("ovf_call%0d_cnt", i), ras_count, call_cnt[i]);
`ifdef PC_UNIT_RAS_EN
            check($sformatf("ovf_call%0d_ovf", i), ras_ovf, (i == 4) ? 1'b1 : 1'b0);
`else
            check($sformatf("ovf_call%0d_ovf", i), ras_ovf, 1'b0);
`endif
        end
        call = 1'b0; ret = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("drain_ret%0d_pc", i), pc, ret_pc[i]);
            check($sformatf("drain_ret%0d_cnt", i), ras_count, ret_cnt[i]);
`ifdef PC_UNIT_RAS_EN
            check($sformatf("drain_ret%0d_unf", i), ras_unf, (i == 4) ? 1'b1 : 1'b0);
`else
            check($sformatf("drain_ret%0d_unf", i), ras_unf, 1'b0);
`endif
        end
        ret = 1'b0;

        // ret + call together with an empty RAS
        reset = 1'b1;
        step(); check("rst3_flags", {ras_ovf, ras_unf}, 2'b00);
        reset = 1'b0;
        step();
        ret = 1'b1; call = 1'b1; jump_target = 16'h0300;
        step();
`ifdef PC_UNIT_RAS_EN
        check("retcall_pc", pc, 16'h0001);
        check("retcall_unf", ras_unf, 1'b1);
`else
        check("retcall_pc", pc, 16'h0300);
        check("retcall_unf", ras_unf, 1'b0);
`endif
        check("retcall_cnt", ras_count, 3'd0);
        check("retcall_ovf", ras_ovf, 1'b0);
        ret = 1'b0; call = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
